mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one SRAM-like bus (req/addr_ok/data_ok) between the IF fetch port (port 0) and the
//  EXE data_sram port (port 1). Data wins by default; a starvation counter guarantees fetch
//  progress. An in-order owner FIFO routes each data_ok back to its issuing port and silently
//  drops fetch responses killed by a pipeline flush. Sits between the stages and the AXI bridge.
// PARAMETERS
//  OUTSTANDING  4   max accepted-but-unanswered transactions (power of 2, >=2)
//  STARVE_MAX   3   consecutive cycles fetch may lose arbitration before it is forced to win
// PORTS
//  clk            in   1   clock
//  resetn         in   1   asynchronous, active-low reset
//  flush          in   1   exception/ertn flush; kills all outstanding fetch transactions
//  p0_req         in   1   fetch request (read only)
//  p0_addr        in   32  fetch address
//  p0_addr_ok     out  1   fetch request accepted this cycle
//  p0_data_ok     out  1   fetch rdata valid this cycle
//  p0_rdata       out  32  fetch read data
//  p1_req         in   1   data request
//  p1_wr          in   1   1=store, 0=load
//  p1_wstrb       in   4   byte strobes (store)
//  p1_addr        in   32  data address
//  p1_wdata       in   32  store data
//  p1_addr_ok     out  1   data request accepted this cycle
//  p1_data_ok     out  1   load data / store completion valid this cycle
//  p1_rdata       out  32  load data
//  m_req/m_wr     out  1   bus request / write flag
//  m_wstrb        out  4   bus strobes (4'b0 on reads)
//  m_addr/m_wdata out  32  bus address / write data
//  m_addr_ok      in   1   bus accepted request
//  m_data_ok      in   1   bus response valid
//  m_rdata        in   32  bus response data
// BEHAVIOUR
//  - Reset: all outputs 0; FIFO empty; starve counter 0; grant state IDLE.
//  - Grant FSM: IDLE -> G0/G1 when a request exists and FIFO not full (occupancy < OUTSTANDING).
//    Winner: p1 unless starve counter == STARVE_MAX with p0_req high. Grant holds (m_* driven
//    from winner, combinationally from port inputs) until m_addr_ok, then IDLE in same cycle:
//    a new grant may be chosen next cycle. No grant switching while m_req=1 and !m_addr_ok.
//  - m_req = (state G0/G1) ; px_addr_ok = m_addr_ok & (state==Gx). Requesters hold inputs stable.
//  - Starve counter: +1 each cycle p0_req=1 and p1 granted; cleared when p0 accepted or p0_req=0;
//    saturates at STARVE_MAX.
//  - Owner FIFO: push {port, kill=0} on m_addr_ok; pop on m_data_ok. Push+pop same cycle: count
//    unchanged. m_data_ok with FIFO empty is a protocol error (assertion), ignored.
//  - Response routing: head.port==1 -> p1_data_ok=m_data_ok, p1_rdata=m_rdata (zero latency).
//    head.port==0 & !kill -> p0_data_ok. head.port==0 & kill -> popped, no px_data_ok.
//  - flush: sets kill on every valid port-0 entry, plus the entry pushed in the same cycle if it
//    is port 0. A port-0 grant pending (no addr_ok yet) is dropped -> IDLE. Port-1 entries untouched.
//  - Pointers wrap modulo OUTSTANDING; count width clog2(OUTSTANDING)+1.
//  - Reset mid-transaction: FIFO cleared; late bus responses after reset are outside contract.
// STRUCTURE
//  - Shared package: port ID localparams (PORT_IF=0, PORT_DATA=1), grant state encoding
//    (IDLE/G0/G1), owner-entry struct {port, kill}.
//  - One sub-module: owner_fifo (depth OUTSTANDING, push/pop/kill_port0, head out, full/empty).
//  - Arbiter FSM, starve counter, response demux in top.
// TESTING
//  1 Fetch only: p0 reads 0x1c000000, 0x1c000004 -> two p0_addr_ok, p0_data_ok in order, rdata
//    matches; p1_* stay 0.
//  2 Contention: p0_req & p1_req held, bus addr_ok every cycle -> p1 wins 3 cycles, 4th grant
//    goes to p0 (STARVE_MAX=3); counter then 0.
//  3 Full: bus withholds data_ok, 4 accepted -> m_req stays 0 with requests pending; one data_ok
//    -> next grant in following cycle.
//  4 Flush: 2 fetches outstanding + 1 store, flush -> 2 fetch responses produce no p0_data_ok,
//    store response gives p1_data_ok=1; later fetch answered normally.
//  5 Flush during held p0 grant (m_addr_ok=0) -> m_req drops next cycle, no FIFO push.
//  6 Reset asserted mid-traffic (resetn=0 async) -> all outputs 0 immediately, FIFO empty after.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory port arbiter: port IDs, grant states and
// the owner-FIFO entry that routes each bus response back to its issuer.
package mem_port_arbiter_pkg;

    localparam logic PORT_IF   = 1'b0;  // instruction fetch
    localparam logic PORT_DATA = 1'b1;  // EXE data_sram

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_G0   = 2'd1,
        ST_G1   = 2'd2
    } grant_state_e;

    // One accepted-but-unanswered transaction. kill marks a fetch whose
    // response must be swallowed because a flush happened after issue.
    typedef struct packed {
        logic port;
        logic kill;
    } owner_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// SRAM-like request/response bundle (req/addr_ok/data_ok). The master
// issues requests; the slave accepts them and returns responses.
interface mem_port_arbiter_if;

    logic        req;
    logic        wr;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (
        output req, wr, wstrb, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, wstrb, addr, wdata,
        output addr_ok, data_ok, rdata
    );

endinterface

// File: rtl/mem_port_arbiter_owner_fifo.sv
// In-order FIFO of transaction owners. The head tells the arbiter which
// port the next bus response belongs to; kill_port0 marks every queued
// fetch (and a fetch being pushed this cycle) as dead.
module mem_port_arbiter_owner_fifo
    import mem_port_arbiter_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic   clk,
    input  logic   resetn,
    input  logic   push,
    input  owner_t push_entry,
    input  logic   pop,
    input  logic   kill_port0,
    output owner_t head,
    output logic   full,
    output logic   empty
);

    localparam int PW = $clog2(DEPTH);

    typedef logic [PW-1:0] ptr_t;
    typedef logic [PW:0]   cnt_t;

    owner_t mem [DEPTH];
    ptr_t   wr_ptr;
    ptr_t   rd_ptr;
    cnt_t   count;
    logic   do_push;
    logic   do_pop;

    assign full    = (count == cnt_t'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr];

    // Entry storage: flush marks queued fetches dead, push writes the tail.
    // NOTE: the storage array has no reset; validity comes only from count,
    // so clearing the pointers is enough and keeps the array a plain RAM.
    // Killing stale (invalid) fetch slots is harmless because a push
    // rewrites the whole entry.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (kill_port0 && (mem[i].port == PORT_IF)) begin
                mem[i].kill <= 1'b1;
            end
        end
        if (do_push) begin
            mem[wr_ptr] <= '{port: push_entry.port,
                             kill: push_entry.kill | (kill_port0 & (push_entry.port == PORT_IF))};
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + ptr_t'(1);
            if (do_pop)  rd_ptr <= rd_ptr + ptr_t'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + cnt_t'(1);
                2'b01:   count <= count - cnt_t'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one SRAM-like bus between the fetch port (p0) and the data port
// (p1). Data wins by default; a starvation counter forces a fetch grant
// after STARVE_MAX lost cycles. Responses return in order through the
// owner FIFO; fetches killed by a flush are answered on the bus but
// never reported to p0.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int OUTSTANDING = 4,
    parameter int STARVE_MAX  = 3
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 flush,
    mem_port_arbiter_if.slave    p0,
    mem_port_arbiter_if.slave    p1,
    mem_port_arbiter_if.master   m
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    typedef logic [SW-1:0] starve_t;

    grant_state_e state;
    starve_t      starve_cnt;
    owner_t       head;
    owner_t       push_entry;
    logic         fifo_full;
    logic         fifo_empty;
    logic         accept;
    logic         pop;
    logic         slot_free;
    logic         p0_wins;
    logic         unused_p0;

    // Fetch is read-only; its write-side bundle signals are ignored.
    assign unused_p0 = ^{p0.wr, p0.wstrb, p0.wdata};

    assign accept     = m.addr_ok && (state != ST_IDLE);
    assign pop        = m.data_ok && !fifo_empty;
    // A response retiring this cycle frees a slot for the grant chosen now.
    assign slot_free  = !fifo_full || pop;
    assign p0_wins    = p0.req && (!p1.req || (starve_cnt == starve_t'(STARVE_MAX)));
    assign push_entry = '{port: (state == ST_G1) ? PORT_DATA : PORT_IF, kill: 1'b0};

    // Grant FSM: pick a winner when idle, hold it until the bus accepts.
    // A flush abandons a fetch grant that has not been accepted yet.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if ((p0.req || p1.req) && slot_free) state <= p0_wins ? ST_G0 : ST_G1;
                ST_G0:   if (accept || flush) state <= ST_IDLE;
                ST_G1:   if (accept) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Starvation counter: counts cycles fetch waits behind a data grant.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            starve_cnt <= '0;
        end else if (!p0.req || (accept && (state == ST_G0))) begin
            starve_cnt <= '0;
        end else if ((state == ST_G1) && (starve_cnt != starve_t'(STARVE_MAX))) begin
            starve_cnt <= starve_cnt + starve_t'(1);
        end
    end

    // Bus request mux: the granted port's inputs pass straight through.
    // NOTE: every output gets a default before the case so no latch is
    // inferred for states that leave a signal untouched.
    always_comb begin
        m.req   = 1'b0;
        m.wr    = 1'b0;
        m.wstrb = 4'b0;
        m.addr  = 32'b0;
        m.wdata = 32'b0;
        case (state)
            ST_G0: begin
                m.req  = 1'b1;
                m.addr = p0.addr;
            end
            ST_G1: begin
                m.req   = 1'b1;
                m.wr    = p1.wr;
                m.wstrb = p1.wr ? p1.wstrb : 4'b0;
                m.addr  = p1.addr;
                m.wdata = p1.wdata;
            end
            default: ;
        endcase
    end

    assign p0.addr_ok = m.addr_ok && (state == ST_G0);
    assign p1.addr_ok = m.addr_ok && (state == ST_G1);

    // Response demux: the FIFO head names the owner of each data_ok.
    assign p1.data_ok = pop && (head.port == PORT_DATA);
    assign p0.data_ok = pop && (head.port == PORT_IF) && !head.kill;
    assign p1.rdata   = p1.data_ok ? m.rdata : 32'b0;
    assign p0.rdata   = p0.data_ok ? m.rdata : 32'b0;

    mem_port_arbiter_owner_fifo #(.DEPTH(OUTSTANDING)) u_owner_fifo (
        .clk        (clk),
        .resetn     (resetn),
        .push       (accept),
        .push_entry (push_entry),
        .pop        (pop),
        .kill_port0 (flush),
        .head       (head),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    // A response with nothing outstanding is a bus protocol violation.
    assert property (@(posedge clk) disable iff (!resetn) !(m.data_ok && fifo_empty));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: reset check, a contention
// vector table, directed corner sequences and a random run compared
// against a transaction-level reference model.
module tb_mem_port_arbiter;

    localparam int N    = 4;
    localparam int SMAX = 3;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    logic flush  = 1'b0;

    always #5 clk = ~clk;

    mem_port_arbiter_if p0 ();
    mem_port_arbiter_if p1 ();
    mem_port_arbiter_if m ();

    mem_port_arbiter #(.OUTSTANDING(N), .STARVE_MAX(SMAX)) dut (
        .clk    (clk),
        .resetn (resetn),
        .flush  (flush),
        .p0     (p0),
        .p1     (p1),
        .m      (m)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: who holds the grant (-1 none), how long fetch has
    // been losing, and the ordered list of outstanding transactions.
    typedef struct { int port; bit killed; } txn_t;
    txn_t owners[$];
    int   grant  = -1;
    int   losses = 0;
    bit   last_p0_acc, last_p1_acc;

    // Observed DUT outputs of the most recent cycle.
    logic        o_mreq, o_p0aok, o_p1aok, o_p0dok, o_p1dok;
    logic [31:0] o_p0rd, o_p1rd, o_maddr;
    int          p0_aok_cnt, p1_aok_cnt, p1_activity;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        flush = 1'b0;
        p0.req = 1'b0; p0.wr = 1'b0; p0.wstrb = 4'h0; p0.addr = 32'h0; p0.wdata = 32'h0;
        p1.req = 1'b0; p1.wr = 1'b0; p1.wstrb = 4'h0; p1.addr = 32'h0; p1.wdata = 32'h0;
        m.addr_ok = 1'b0; m.data_ok = 1'b0; m.rdata = 32'h0;
    endtask

    task automatic model_reset();
        owners.delete();
        grant = -1;
        losses = 0;
        last_p0_acc = 1'b0;
        last_p1_acc = 1'b0;
    endtask

    // Advance the model by one clock using the inputs of the current cycle.
    task automatic model_step();
        bit acc, pop;
        int next_grant;
        acc = (m.addr_ok === 1'b1) && (grant >= 0);
        pop = (m.data_ok === 1'b1) && (owners.size() > 0);
        next_grant = grant;
        if (grant >= 0) begin
            if (acc || (flush && grant == 0)) next_grant = -1;
        end else if ((p0.req || p1.req) && (owners.size() - int'(pop)) < N) begin
            // Data port wins unless it is idle or fetch has lost SMAX cycles.
            next_grant = (p1.req && !(p0.req && losses == SMAX)) ? 1 : 0;
        end
        if (!p0.req || (acc && grant == 0)) losses = 0;
        else if (grant == 1 && losses < SMAX) losses++;
        if (pop) void'(owners.pop_front());
        if (flush) foreach (owners[i]) if (owners[i].port == 0) owners[i].killed = 1'b1;
        if (acc) owners.push_back('{port: grant, killed: flush && (grant == 0)});
        last_p0_acc = acc && (grant == 0);
        last_p1_acc = acc && (grant == 1);
        grant = next_grant;
    endtask

    // One clock: sample at negedge, compare with the model, step, move past posedge.
    task automatic tick();
        logic e_mreq, e_p0aok, e_p1aok, e_p0dok, e_p1dok;
        @(negedge clk);
        o_mreq = m.req; o_p0aok = p0.addr_ok; o_p1aok = p1.addr_ok;
        o_p0dok = p0.data_ok; o_p1dok = p1.data_ok;
        o_p0rd = p0.rdata; o_p1rd = p1.rdata; o_maddr = m.addr;
        e_mreq  = (grant >= 0);
        e_p0aok = m.addr_ok && (grant == 0);
        e_p1aok = m.addr_ok && (grant == 1);
        e_p0dok = 1'b0;
        e_p1dok = 1'b0;
        if (m.data_ok && owners.size() > 0) begin
            if (owners[0].port == 1) e_p1dok = 1'b1;
            else e_p0dok = !owners[0].killed;
        end
        check("m_req", 32'(o_mreq), 32'(e_mreq));
        check("p0_addr_ok", 32'(o_p0aok), 32'(e_p0aok));
        check("p1_addr_ok", 32'(o_p1aok), 32'(e_p1aok));
        check("p0_data_ok", 32'(o_p0dok), 32'(e_p0dok));
        check("p1_data_ok", 32'(o_p1dok), 32'(e_p1dok));
        if (e_mreq) begin
            check("m_addr", o_maddr, (grant == 0) ? p0.addr : p1.addr);
            check("m_wr", 32'(m.wr), 32'((grant == 1) && p1.wr));
            check("m_wstrb", 32'(m.wstrb), ((grant == 1) && p1.wr) ? 32'(p1.wstrb) : 32'h0);
            if (grant == 1 && p1.wr) check("m_wdata", m.wdata, p1.wdata);
        end
        if (e_p0dok) check("p0_rdata", o_p0rd, m.rdata);
        if (e_p1dok) check("p1_rdata", o_p1rd, m.rdata);
        if (o_p0aok) p0_aok_cnt++;
        if (o_p1aok) p1_aok_cnt++;
        if (o_p1aok || o_p1dok || o_p1rd != 32'h0) p1_activity++;
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        clear_inputs();
        @(posedge clk);
        #1;
        check("rst_m_req", 32'(m.req), 32'h0);
        check("rst_p0_addr_ok", 32'(p0.addr_ok), 32'h0);
        check("rst_p1_data_ok", 32'(p1.data_ok), 32'h0);
        @(negedge clk);
        resetn = 1'b1;
        model_reset();
        p0_aok_cnt = 0;
        p1_aok_cnt = 0;
        p1_activity = 0;
        @(posedge clk);
        #1;
    endtask

    // Present one request and let the bus accept it as soon as it is granted.
    task automatic issue(input int port, input logic [31:0] addr, input logic wr);
        bit done;
        done = 1'b0;
        if (port == 0) begin
            p0.req = 1'b1; p0.addr = addr;
        end else begin
            p1.req = 1'b1; p1.addr = addr; p1.wr = wr;
            p1.wstrb = wr ? 4'hf : 4'h3;
            p1.wdata = addr ^ 32'h5a5a_5a5a;
        end
        for (int k = 0; k < 20 && !done; k++) begin
            m.addr_ok = (grant >= 0);
            tick();
            done = (port == 0) ? o_p0aok : o_p1aok;
        end
        check("issue_accepted", 32'(done), 32'h1);
        if (port == 0) p0.req = 1'b0; else p1.req = 1'b0;
        m.addr_ok = 1'b0;
    endtask

    task automatic respond(input logic [31:0] rd);
        m.data_ok = 1'b1;
        m.rdata = rd;
        tick();
        m.data_ok = 1'b0;
        m.rdata = 32'h0;
    endtask

    typedef struct {
        logic        aok, dok;
        logic [31:0] rdata;
        logic        e_mreq, e_p0aok, e_p1aok, e_p0dok, e_p1dok;
        logic [31:0] e_maddr;
    } vec_t;

    localparam logic [31:0] P0A = 32'h1c00_0100;
    localparam logic [31:0] P1A = 32'h0000_1000;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t tbl [10];
        clear_inputs();

        // 1: fetch only, two reads answered in order, data port quiet.
        do_reset();
        issue(0, 32'h1c00_0000, 1'b0);
        issue(0, 32'h1c00_0004, 1'b0);
        respond(32'h1111_1111);
        check("t1_dok0", 32'(o_p0dok), 32'h1);
        check("t1_rd0", o_p0rd, 32'h1111_1111);
        respond(32'h2222_2222);
        check("t1_dok1", 32'(o_p0dok), 32'h1);
        check("t1_rd1", o_p0rd, 32'h2222_2222);
        check("t1_aok_count", 32'(p0_aok_cnt), 32'd2);
        check("t1_p1_quiet", 32'(p1_activity), 32'd0);

        // 2: contention table; p1 wins three grants, the fourth goes to p0,
        //    and the next grant returns to p1 because the counter cleared.
        tbl[0] = '{1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
        tbl[1] = '{1'b1, 1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, P1A};
        tbl[2] = '{1'b0, 1'b1, 32'ha0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0};
        tbl[3] = '{1'b1, 1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, P1A};
        tbl[4] = '{1'b0, 1'b1, 32'ha1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0};
        tbl[5] = '{1'b1, 1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, P1A};
        tbl[6] = '{1'b0, 1'b1, 32'ha2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0};
        tbl[7] = '{1'b1, 1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, P0A};
        tbl[8] = '{1'b0, 1'b1, 32'ha3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0};
        tbl[9] = '{1'b1, 1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, P1A};
        do_reset();
        p0.req = 1'b1; p0.addr = P0A;
        p1.req = 1'b1; p1.addr = P1A; p1.wr = 1'b1; p1.wstrb = 4'hf; p1.wdata = 32'hdead_beef;
        for (int i = 0; i < 10; i++) begin
            m.addr_ok = tbl[i].aok;
            m.data_ok = tbl[i].dok;
            m.rdata = tbl[i].rdata;
            tick();
            check($sformatf("t2_mreq[%0d]", i), 32'(o_mreq), 32'(tbl[i].e_mreq));
            check($sformatf("t2_p0aok[%0d]", i), 32'(o_p0aok), 32'(tbl[i].e_p0aok));
            check($sformatf("t2_p1aok[%0d]", i), 32'(o_p1aok), 32'(tbl[i].e_p1aok));
            check($sformatf("t2_p0dok[%0d]", i), 32'(o_p0dok), 32'(tbl[i].e_p0dok));
            check($sformatf("t2_p1dok[%0d]", i), 32'(o_p1dok), 32'(tbl[i].e_p1dok));
            if (tbl[i].e_mreq) check($sformatf("t2_maddr[%0d]", i), o_maddr, tbl[i].e_maddr);
            if (tbl[i].e_p0dok) check($sformatf("t2_p0rd[%0d]", i), o_p0rd, tbl[i].rdata);
            if (tbl[i].e_p1dok) check($sformatf("t2_p1rd[%0d]", i), o_p1rd, tbl[i].rdata);
        end
        clear_inputs();

        // 3: four accepted with no responses -> stall; one response -> regrant.
        do_reset();
        p1.req = 1'b1; p1.wr = 1'b1; p1.wstrb = 4'hf; p1.addr = 32'h2000; p1.wdata = 32'h1234;
        for (int i = 0; i < 12; i++) begin
            m.addr_ok = (grant >= 0);
            tick();
        end
        check("t3_accepted", 32'(p1_aok_cnt), 32'd4);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t3_stall_mreq", 32'(o_mreq), 32'h0);
        end
        respond(32'h33);
        check("t3_resp_mreq", 32'(o_mreq), 32'h0);
        check("t3_resp_dok", 32'(o_p1dok), 32'h1);
        tick();
        check("t3_regrant", 32'(o_mreq), 32'h1);
        m.addr_ok = 1'b1;
        tick();
        clear_inputs();

        // 4: flush kills two outstanding fetches; the store still completes.
        do_reset();
        issue(0, 32'h1c00_0010, 1'b0);
        issue(0, 32'h1c00_0014, 1'b0);
        issue(1, 32'h0000_3000, 1'b1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        respond(32'h4444_0001);
        check("t4_kill_a", 32'(o_p0dok | o_p1dok), 32'h0);
        respond(32'h4444_0002);
        check("t4_kill_b", 32'(o_p0dok | o_p1dok), 32'h0);
        respond(32'h4444_0003);
        check("t4_store_dok", 32'(o_p1dok), 32'h1);
        check("t4_store_rd", o_p1rd, 32'h4444_0003);
        issue(0, 32'h1c00_0018, 1'b0);
        respond(32'h4444_0004);
        check("t4_after_dok", 32'(o_p0dok), 32'h1);
        check("t4_after_rd", o_p0rd, 32'h4444_0004);

        // 5: flush while a fetch grant waits for addr_ok -> grant dropped.
        do_reset();
        p0.req = 1'b1; p0.addr = 32'h1c00_0020;
        tick();
        flush = 1'b1;
        tick();
        check("t5_held", 32'(o_mreq), 32'h1);
        flush = 1'b0;
        p0.req = 1'b0;
        tick();
        check("t5_drop", 32'(o_mreq), 32'h0);
        issue(1, 32'h0000_4000, 1'b0);
        respond(32'h5555_0000);
        check("t5_no_push", 32'(o_p1dok), 32'h1);

        // 6: asynchronous reset in the middle of traffic.
        do_reset();
        issue(1, 32'h0000_5000, 1'b1);
        p0.req = 1'b1; p0.addr = 32'h1c00_0030;
        p1.req = 1'b1; p1.addr = 32'h0000_5004; p1.wr = 1'b1; p1.wstrb = 4'hf; p1.wdata = 32'h66;
        tick();
        tick();
        m.addr_ok = 1'b1; m.data_ok = 1'b1; m.rdata = 32'hffff_ffff;
        #1;
        resetn = 1'b0;
        #1;
        check("t6_m_req", 32'(m.req), 32'h0);
        check("t6_m_wr", 32'(m.wr), 32'h0);
        check("t6_m_wstrb", 32'(m.wstrb), 32'h0);
        check("t6_m_addr", m.addr, 32'h0);
        check("t6_m_wdata", m.wdata, 32'h0);
        check("t6_p0_addr_ok", 32'(p0.addr_ok), 32'h0);
        check("t6_p1_addr_ok", 32'(p1.addr_ok), 32'h0);
        check("t6_p0_data_ok", 32'(p0.data_ok), 32'h0);
        check("t6_p1_data_ok", 32'(p1.data_ok), 32'h0);
        check("t6_p0_rdata", p0.rdata, 32'h0);
        check("t6_p1_rdata", p1.rdata, 32'h0);
        clear_inputs();
        model_reset();
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        issue(0, 32'h1c00_0040, 1'b0);
        respond(32'h6666_0001);
        check("t6_fifo_empty_p0", 32'(o_p0dok), 32'h1);
        check("t6_fifo_empty_p1", 32'(o_p1dok), 32'h0);

        // Random traffic against the reference model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if (!p0.req || last_p0_acc || (flush && ($urandom % 2 == 0))) begin
                p0.req  = ($urandom % 3) != 0;
                p0.addr = $urandom & 32'hffff_fffc;
            end
            if (!p1.req || last_p1_acc) begin
                p1.req   = ($urandom % 3) != 0;
                p1.wr    = $urandom % 2;
                p1.wstrb = 4'($urandom);
                p1.addr  = $urandom & 32'hffff_fffc;
                p1.wdata = $urandom;
            end
            m.addr_ok = (grant >= 0) && ($urandom % 2 == 0);
            m.data_ok = (owners.size() > 0) && ($urandom % 3 == 0);
            m.rdata   = $urandom;
            flush     = ($urandom % 12) == 0;
            tick();
        end
        clear_inputs();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
